pkt_receiver: RTL and testbench

- Terminates the 72-bit SpiNNaker-format packet stream arriving from the transceiver.
- Three destinations for each packet:
  - Configuration packets (key in the receiver's key window) carrying a payload become register-bank writes.
  - Configuration packets without a payload are counter reads; each is answered with a diagnostic counter packet (DCP).
  - All other packets pass unchanged to the peripheral output.
- Sits between the transceiver receive path and the register bank / peripheral in spif.

---
 rtl/spif_pkg.sv | 26 ++
 rtl/pkt_out_reg.sv | 52 +++++
 rtl/pkt_receiver.sv | 179 +++++++++++++++++
 tb/tb_pkt_receiver.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spif_pkg.sv
// spif_pkg: definitions shared by the packet receiver blocks.
//   - PACKET_BITS, field offsets and header bit positions of the 72-bit
//     packet {payload[71:40], key[39:8], header[7:0]}.
//   - pkt_t: packed struct view of a packet.
//   - odd_parity_bit(): bit to place in header[0] so the packet has odd parity.
package spif_pkg;

  localparam int PACKET_BITS     = 72;
  localparam int KEY_LSB         = 8;
  localparam int PAYLOAD_LSB     = 40;
  localparam int HDR_PARITY_BIT  = 0;
  localparam int HDR_PAYLOAD_BIT = 1;

  typedef struct packed {
    logic [31:0] payload;
    logic [31:0] key;
    logic [7:0]  header;
  } pkt_t;

  // The argument must carry 0 in the parity position; the result is the
  // value that makes the total number of ones odd.
  function automatic logic odd_parity_bit(input logic [PACKET_BITS-1:0] pkt);
    return ~(^pkt);
  endfunction

endpackage

// File: rtl/pkt_out_reg.sv
// pkt_out_reg: one-entry valid/ready output register.
//   clk      in   clock
//   reset    in   asynchronous active-low reset (clears valid and data)
//   load_in  in   capture data_in this cycle; the caller only loads when the
//                 slot is empty or being drained in the same cycle
//   data_in  in   WIDTH  data to capture
//   data_out out  WIDTH  held data, stable while vld_out && !rdy_in
//   vld_out  out  output valid
//   rdy_in   in   downstream ready
module pkt_out_reg
  import spif_pkg::*;
#(
  parameter int WIDTH = PACKET_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             vld_out,
  input  logic             rdy_in
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (load_in) begin
      // A refill in the same cycle as a drain keeps valid high.
      data_d = data_in;
      vld_d  = 1'b1;
    end else if (rdy_in) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign data_out = data_q;
  assign vld_out  = vld_q;

endmodule

// File: rtl/pkt_receiver.sv
// pkt_receiver: terminates the packet stream from the transceiver and
// splits it three ways.
//   - key in config window, payload present : register write (prx_*)
//   - key in config window, no payload      : counter read, answered by a
//                                             diagnostic counter packet (dcp_*)
//   - anything else                         : passed unchanged (per_*)
// Ports:
//   clk, reset (async active-low)
//   pkt_data_in/pkt_vld_in/pkt_rdy_out : incoming packet handshake
//   reg_ctr_in[NUM_CREGS]              : counter values for DCP replies
//   reply_key_in                       : base key of DCP replies
//   prx_addr_out/prx_wdata_out/prx_en_out : register write port
//   dcp_data_out/dcp_vld_out/dcp_rdy_in   : DCP output
//   per_data_out/per_vld_out/per_rdy_in   : peripheral output
//   prx_cnt_out : [0] peripheral packet accepted, [1] config packet accepted
// Every path has one cycle of latency. Both outputs share one ready, so a
// stall on either output holds the input and packet order is preserved.
module pkt_receiver
  import spif_pkg::*;
#(
  parameter int          NUM_CREGS = 3,
  parameter logic [31:0] PRX_KEY   = 32'hffff_fd00,
  parameter logic [31:0] PRX_MSK   = 32'hffff_ff00
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic [PACKET_BITS-1:0] pkt_data_in,
  input  logic                   pkt_vld_in,
  output logic                   pkt_rdy_out,

  input  logic [31:0]            reg_ctr_in [NUM_CREGS],
  input  logic [31:0]            reply_key_in,

  output logic [7:0]             prx_addr_out,
  output logic [31:0]            prx_wdata_out,
  output logic                   prx_en_out,

  output logic [PACKET_BITS-1:0] dcp_data_out,
  output logic                   dcp_vld_out,
  input  logic                   dcp_rdy_in,

  output logic [PACKET_BITS-1:0] per_data_out,
  output logic                   per_vld_out,
  input  logic                   per_rdy_in,

  output logic [1:0]             prx_cnt_out
);

  // --------------------------------------------------------------------
  // Input decode
  // --------------------------------------------------------------------
  logic [31:0] in_key;
  logic [31:0] in_payload;
  logic [7:0]  ctr_idx;
  logic        is_cfg;
  logic        has_pl;
  logic        accept;

  assign in_key     = pkt_data_in[KEY_LSB +: 32];
  assign in_payload = pkt_data_in[PAYLOAD_LSB +: 32];
  assign ctr_idx    = in_key[7:0];
  assign is_cfg     = ((in_key & PRX_MSK) == (PRX_MSK & PRX_KEY));
  assign has_pl     = pkt_data_in[HDR_PAYLOAD_BIT];

  // run_q holds ready low while reset is asserted; after release the
  // ready is purely a function of the output stages.
  logic run_q, run_d;

  assign run_d       = 1'b1;
  assign pkt_rdy_out = run_q
                     && (!per_vld_out || per_rdy_in)
                     && (!dcp_vld_out || dcp_rdy_in);
  assign accept      = pkt_vld_in && pkt_rdy_out;

  // --------------------------------------------------------------------
  // Counter select: indices outside the bank read as zero because no
  // select term matches them.
  // --------------------------------------------------------------------
  logic [31:0] ctr_sel [NUM_CREGS];
  logic [31:0] ctr_value;

  for (genvar gi = 0; gi < NUM_CREGS; gi++) begin : g_ctr_sel
    assign ctr_sel[gi] = (ctr_idx == 8'(gi)) ? reg_ctr_in[gi] : 32'h0;
  end

  always_comb begin
    ctr_value = 32'h0;
    for (int c = 0; c < NUM_CREGS; c++) begin
      ctr_value = ctr_value | ctr_sel[c];
    end
  end

  // --------------------------------------------------------------------
  // DCP construction: header 8'h02 (payload present), parity in bit 0
  // --------------------------------------------------------------------
  pkt_t dcp_raw;
  pkt_t dcp_pkt;

  always_comb begin
    dcp_raw                         = '0;
    dcp_raw.payload                 = ctr_value;
    dcp_raw.key                     = reply_key_in | {24'h0, ctr_idx};
    dcp_raw.header[HDR_PAYLOAD_BIT] = 1'b1;
    dcp_pkt                         = dcp_raw;
    dcp_pkt.header[HDR_PARITY_BIT]  = odd_parity_bit(dcp_raw);
  end

  // --------------------------------------------------------------------
  // Output stages
  // --------------------------------------------------------------------
  logic dcp_load;
  logic per_load;

  assign dcp_load = accept &&  is_cfg && !has_pl;
  assign per_load = accept && !is_cfg;

  pkt_out_reg #(.WIDTH(PACKET_BITS)) u_dcp_reg (
    .clk      (clk),
    .reset    (reset),
    .load_in  (dcp_load),
    .data_in  (dcp_pkt),
    .data_out (dcp_data_out),
    .vld_out  (dcp_vld_out),
    .rdy_in   (dcp_rdy_in)
  );

  pkt_out_reg #(.WIDTH(PACKET_BITS)) u_per_reg (
    .clk      (clk),
    .reset    (reset),
    .load_in  (per_load),
    .data_in  (pkt_data_in),
    .data_out (per_data_out),
    .vld_out  (per_vld_out),
    .rdy_in   (per_rdy_in)
  );

  // --------------------------------------------------------------------
  // Register write port and counter-enable pulses
  // --------------------------------------------------------------------
  logic        prx_en_q,    prx_en_d;
  logic [7:0]  prx_addr_q,  prx_addr_d;
  logic [31:0] prx_wdata_q, prx_wdata_d;
  logic [1:0]  cnt_q,       cnt_d;

  always_comb begin
    prx_en_d    = 1'b0;
    prx_addr_d  = prx_addr_q;   // address/data hold between writes
    prx_wdata_d = prx_wdata_q;
    if (accept && is_cfg && has_pl) begin
      prx_en_d    = 1'b1;
      prx_addr_d  = ctr_idx;
      prx_wdata_d = in_payload;
    end
    cnt_d = {accept && is_cfg, accept && !is_cfg};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q       <= 1'b0;
      prx_en_q    <= 1'b0;
      prx_addr_q  <= 8'h0;
      prx_wdata_q <= 32'h0;
      cnt_q       <= 2'b00;
    end else begin
      run_q       <= run_d;
      prx_en_q    <= prx_en_d;
      prx_addr_q  <= prx_addr_d;
      prx_wdata_q <= prx_wdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign prx_en_out    = prx_en_q;
  assign prx_addr_out  = prx_addr_q;
  assign prx_wdata_out = prx_wdata_q;
  assign prx_cnt_out   = cnt_q;

endmodule

// File: tb/tb_pkt_receiver.sv
// tb_pkt_receiver: directed self-checking bench for pkt_receiver.
// Inputs are driven on the falling edge and outputs sampled on the falling
// edge, so each check sees the result of the preceding rising edge.
// Counters: reg_ctr_in = {1, 7, A5A5_0000}, reply_key_in = 0000_0100.
module tb_pkt_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic [71:0] pkt_data_in;
  logic        pkt_vld_in;
  logic        pkt_rdy_out;
  logic [31:0] reg_ctr_in [3];
  logic [31:0] reply_key_in;
  logic [7:0]  prx_addr_out;
  logic [31:0] prx_wdata_out;
  logic        prx_en_out;
  logic [71:0] dcp_data_out;
  logic        dcp_vld_out;
  logic        dcp_rdy_in;
  logic [71:0] per_data_out;
  logic        per_vld_out;
  logic        per_rdy_in;
  logic [1:0]  prx_cnt_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pkt_receiver dut (
    .clk           (clk),
    .reset         (reset),
    .pkt_data_in   (pkt_data_in),
    .pkt_vld_in    (pkt_vld_in),
    .pkt_rdy_out   (pkt_rdy_out),
    .reg_ctr_in    (reg_ctr_in),
    .reply_key_in  (reply_key_in),
    .prx_addr_out  (prx_addr_out),
    .prx_wdata_out (prx_wdata_out),
    .prx_en_out    (prx_en_out),
    .dcp_data_out  (dcp_data_out),
    .dcp_vld_out   (dcp_vld_out),
    .dcp_rdy_in    (dcp_rdy_in),
    .per_data_out  (per_data_out),
    .per_vld_out   (per_vld_out),
    .per_rdy_in    (per_rdy_in),
    .prx_cnt_out   (prx_cnt_out)
  );

  task automatic send(input logic [71:0] p);
    pkt_data_in = p;
    pkt_vld_in  = 1'b1;
    $display("tx payload=%h key=%h hdr=%h", p[71:40], p[39:8], p[7:0]);
  endtask

  task automatic test_reset();
    reset = 1'b0; pkt_vld_in = 1'b0; pkt_data_in = '0;
    dcp_rdy_in = 1'b1; per_rdy_in = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (pkt_rdy_out !== 1'b0) begin bad++; $display("FAIL reset_rdy: got %b want 0", pkt_rdy_out); end
    total++; if ({per_vld_out, dcp_vld_out, prx_en_out, prx_cnt_out} !== 5'b0) begin bad++;
      $display("FAIL reset_ctl: got %b want 00000", {per_vld_out, dcp_vld_out, prx_en_out, prx_cnt_out}); end
    total++; if ({per_data_out, dcp_data_out} !== 144'h0) begin bad++;
      $display("FAIL reset_data: per=%h dcp=%h want 0", per_data_out, dcp_data_out); end
    total++; if ({prx_addr_out, prx_wdata_out} !== 40'h0) begin bad++;
      $display("FAIL reset_wr: got %h want 0", {prx_addr_out, prx_wdata_out}); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (pkt_rdy_out !== 1'b1) begin bad++; $display("FAIL rdy_after_reset: got %b want 1", pkt_rdy_out); end
  endtask

  task automatic test_stream();
    logic [71:0] exp_q [6];
    int pulses = 0;
    for (int j = 0; j <= 7; j++) begin
      @(negedge clk);
      if (prx_cnt_out[0]) pulses++;
      if (j >= 1 && j <= 6) begin
        total++; if (per_vld_out !== 1'b1 || per_data_out !== exp_q[j-1]) begin bad++;
          $display("FAIL stream_%0d: vld=%b data=%h want 1 %h", j-1, per_vld_out, per_data_out, exp_q[j-1]); end
        total++; if (pkt_rdy_out !== 1'b1 || dcp_vld_out !== 1'b0 || prx_en_out !== 1'b0) begin bad++;
          $display("FAIL stream_side_%0d: rdy=%b dcp=%b en=%b want 1 0 0", j-1, pkt_rdy_out, dcp_vld_out, prx_en_out); end
      end else if (j == 7) begin
        total++; if (per_vld_out !== 1'b0) begin bad++; $display("FAIL stream_drain: vld=%b want 0", per_vld_out); end
      end
      if (j < 6) begin
        exp_q[j] = {32'hA000_0000 + 32'(j), 32'(j), 8'h00};
        send(exp_q[j]);
      end else begin
        pkt_vld_in = 1'b0;
      end
    end
    total++; if (pulses != 6) begin bad++; $display("FAIL stream_cnt0: got %0d pulses want 6", pulses); end
  endtask

  task automatic test_key_window();
    logic [31:0] keys [3] = '{32'hffff_fc00, 32'hffff_fe00, 32'h7fff_fd00};
    logic [71:0] p;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      p = {32'h1234_0000 + 32'(j), keys[j], 8'h02};
      send(p);
      @(negedge clk);
      pkt_vld_in = 1'b0;
      total++; if (per_vld_out !== 1'b1 || per_data_out !== p || prx_cnt_out !== 2'b01 || prx_en_out !== 1'b0) begin bad++;
        $display("FAIL window_%h: vld=%b data=%h cnt=%b en=%b want 1 %h 01 0", keys[j], per_vld_out, per_data_out, prx_cnt_out, prx_en_out, p); end
    end
    @(negedge clk);
  endtask

  task automatic test_reads();
    logic [71:0] in_q  [5] = '{{32'hdead_beef, 32'hffff_fd00, 8'h31},
                               {32'h0000_0000, 32'hffff_fd01, 8'h30},
                               {32'h0000_0000, 32'hffff_fd02, 8'h00},
                               {32'h0000_0000, 32'hffff_fd03, 8'h01},
                               {32'h0000_0000, 32'hffff_fd40, 8'hfd}};
    logic [71:0] exp_q [5] = '{{32'h0000_0001, 32'h0000_0100, 8'h02},
                               {32'h0000_0007, 32'h0000_0101, 8'h03},
                               {32'hA5A5_0000, 32'h0000_0102, 8'h02},
                               {32'h0000_0000, 32'h0000_0103, 8'h03},
                               {32'h0000_0000, 32'h0000_0140, 8'h02}};
    @(negedge clk);
    for (int j = 0; j <= 5; j++) begin
      if (j < 5) send(in_q[j]); else pkt_vld_in = 1'b0;
      @(negedge clk);
      if (j < 5) begin
        total++; if (dcp_vld_out !== 1'b1 || dcp_data_out !== exp_q[j]) begin bad++;
          $display("FAIL read_%0d: vld=%b dcp=%h want 1 %h", j, dcp_vld_out, dcp_data_out, exp_q[j]); end
        total++; if (prx_cnt_out !== 2'b10 || per_vld_out !== 1'b0 || prx_en_out !== 1'b0) begin bad++;
          $display("FAIL read_side_%0d: cnt=%b per=%b en=%b want 10 0 0", j, prx_cnt_out, per_vld_out, prx_en_out); end
      end else begin
        total++; if (dcp_vld_out !== 1'b0 || prx_cnt_out !== 2'b00) begin bad++;
          $display("FAIL read_drain: vld=%b cnt=%b want 0 00", dcp_vld_out, prx_cnt_out); end
      end
    end
  endtask

  task automatic test_writes();
    @(negedge clk);
    send({32'h0000_000d, 32'hffff_fd41, 8'h32});
    @(negedge clk);
    total++; if (prx_en_out !== 1'b1 || prx_addr_out !== 8'h41 || prx_wdata_out !== 32'h0000_000d) begin bad++;
      $display("FAIL write1: en=%b addr=%h data=%h want 1 41 0000000d", prx_en_out, prx_addr_out, prx_wdata_out); end
    total++; if (prx_cnt_out !== 2'b10 || dcp_vld_out !== 1'b0 || per_vld_out !== 1'b0) begin bad++;
      $display("FAIL write1_side: cnt=%b dcp=%b per=%b want 10 0 0", prx_cnt_out, dcp_vld_out, per_vld_out); end
    send({32'h1234_5678, 32'hffff_fdff, 8'h02});
    @(negedge clk);
    pkt_vld_in = 1'b0;
    total++; if (prx_en_out !== 1'b1 || prx_addr_out !== 8'hff || prx_wdata_out !== 32'h1234_5678) begin bad++;
      $display("FAIL write2: en=%b addr=%h data=%h want 1 ff 12345678", prx_en_out, prx_addr_out, prx_wdata_out); end
    @(negedge clk);
    total++; if (prx_en_out !== 1'b0 || prx_addr_out !== 8'hff || prx_wdata_out !== 32'h1234_5678) begin bad++;
      $display("FAIL write_hold: en=%b addr=%h data=%h want 0 ff 12345678", prx_en_out, prx_addr_out, prx_wdata_out); end
  endtask

  task automatic test_back_to_back();
    logic [71:0] p0 = {32'h1111_1111, 32'h0000_1000, 8'h00};
    logic [71:0] p1 = {32'h2222_2222, 32'hffff_fc05, 8'h00};
    send(p0);
    @(negedge clk);
    total++; if (per_vld_out !== 1'b1 || per_data_out !== p0 || prx_cnt_out !== 2'b01) begin bad++;
      $display("FAIL b2b_p0: vld=%b data=%h cnt=%b", per_vld_out, per_data_out, prx_cnt_out); end
    send({32'h0, 32'hffff_fd01, 8'h00});
    @(negedge clk);
    total++; if (dcp_vld_out !== 1'b1 || dcp_data_out !== {32'h0000_0007, 32'h0000_0101, 8'h03} || per_vld_out !== 1'b0) begin bad++;
      $display("FAIL b2b_read: dcp=%b %h per=%b want 1 %h 0", dcp_vld_out, dcp_data_out, per_vld_out, {32'h0000_0007, 32'h0000_0101, 8'h03}); end
    send({32'hCAFE_F00D, 32'hffff_fd10, 8'h02});
    @(negedge clk);
    total++; if (prx_en_out !== 1'b1 || prx_addr_out !== 8'h10 || prx_wdata_out !== 32'hCAFE_F00D || dcp_vld_out !== 1'b0) begin bad++;
      $display("FAIL b2b_write: en=%b addr=%h data=%h dcp=%b", prx_en_out, prx_addr_out, prx_wdata_out, dcp_vld_out); end
    send(p1);
    @(negedge clk);
    pkt_vld_in = 1'b0;
    total++; if (per_vld_out !== 1'b1 || per_data_out !== p1 || prx_en_out !== 1'b0 || prx_cnt_out !== 2'b01) begin bad++;
      $display("FAIL b2b_p1: vld=%b data=%h en=%b cnt=%b", per_vld_out, per_data_out, prx_en_out, prx_cnt_out); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [71:0] exp_dcp2 = {32'hA5A5_0000, 32'h0000_0102, 8'h02};
    logic [71:0] exp_dcp0 = {32'h0000_0001, 32'h0000_0100, 8'h02};
    logic [71:0] per_pkt  = {32'h5555_AAAA, 32'h0000_0077, 8'h00};
    // stalled DCP blocks a peripheral packet
    dcp_rdy_in = 1'b0;
    send({32'h0, 32'hffff_fd02, 8'h00});
    @(negedge clk);
    total++; if (dcp_vld_out !== 1'b1 || dcp_data_out !== exp_dcp2 || pkt_rdy_out !== 1'b0) begin bad++;
      $display("FAIL bp_dcp_load: vld=%b dcp=%h rdy=%b want 1 %h 0", dcp_vld_out, dcp_data_out, pkt_rdy_out, exp_dcp2); end
    send(per_pkt);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (pkt_rdy_out !== 1'b0 || dcp_vld_out !== 1'b1 || dcp_data_out !== exp_dcp2 || per_vld_out !== 1'b0 || prx_cnt_out !== 2'b00) begin bad++;
        $display("FAIL bp_dcp_hold_%0d: rdy=%b vld=%b dcp=%h per=%b cnt=%b", c, pkt_rdy_out, dcp_vld_out, dcp_data_out, per_vld_out, prx_cnt_out); end
    end
    dcp_rdy_in = 1'b1;
    #1;
    total++; if (pkt_rdy_out !== 1'b1) begin bad++; $display("FAIL bp_dcp_release_rdy: got %b want 1", pkt_rdy_out); end
    @(negedge clk);
    pkt_vld_in = 1'b0;
    total++; if (dcp_vld_out !== 1'b0 || per_vld_out !== 1'b1 || per_data_out !== per_pkt || prx_cnt_out !== 2'b01) begin bad++;
      $display("FAIL bp_dcp_drain: dcp=%b per=%b data=%h cnt=%b want 0 1 %h 01", dcp_vld_out, per_vld_out, per_data_out, prx_cnt_out, per_pkt); end
    // stalled peripheral output blocks a counter read
    per_rdy_in = 1'b0;
    @(negedge clk);
    send({32'h0, 32'hffff_fd00, 8'h00});
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++; if (pkt_rdy_out !== 1'b0 || per_vld_out !== 1'b1 || per_data_out !== per_pkt || dcp_vld_out !== 1'b0) begin bad++;
        $display("FAIL bp_per_hold_%0d: rdy=%b per=%b data=%h dcp=%b", c, pkt_rdy_out, per_vld_out, per_data_out, dcp_vld_out); end
    end
    per_rdy_in = 1'b1;
    @(negedge clk);
    pkt_vld_in = 1'b0;
    total++; if (per_vld_out !== 1'b0 || dcp_vld_out !== 1'b1 || dcp_data_out !== exp_dcp0 || prx_cnt_out !== 2'b10) begin bad++;
      $display("FAIL bp_per_drain: per=%b dcp=%b %h cnt=%b want 0 1 %h 10", per_vld_out, dcp_vld_out, dcp_data_out, prx_cnt_out, exp_dcp0); end
    @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    dcp_rdy_in = 1'b0;
    send({32'h0, 32'hffff_fd01, 8'h00});
    @(negedge clk);
    pkt_vld_in = 1'b0;
    total++; if (dcp_vld_out !== 1'b1) begin bad++; $display("FAIL mid_load: dcp=%b want 1", dcp_vld_out); end
    reset = 1'b0;
    #1;
    total++; if (dcp_vld_out !== 1'b0 || dcp_data_out !== 72'h0 || pkt_rdy_out !== 1'b0) begin bad++;
      $display("FAIL mid_reset: dcp=%b %h rdy=%b want 0 0 0", dcp_vld_out, dcp_data_out, pkt_rdy_out); end
    @(negedge clk);
    reset = 1'b1;
    dcp_rdy_in = 1'b1;
    @(negedge clk);
    total++; if (pkt_rdy_out !== 1'b1 || dcp_vld_out !== 1'b0) begin bad++;
      $display("FAIL mid_recover: rdy=%b dcp=%b want 1 0", pkt_rdy_out, dcp_vld_out); end
  endtask

  initial begin
    reg_ctr_in[0] = 32'h0000_0001;
    reg_ctr_in[1] = 32'h0000_0007;
    reg_ctr_in[2] = 32'hA5A5_0000;
    reply_key_in  = 32'h0000_0100;
    test_reset();
    test_stream();
    test_key_window();
    test_reads();
    test_writes();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
